// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - note-table melody player (tone/sound_en per note, silent gaps); MELODY_LOOP_EN repeats the melody
module melody_sequencer #(
    parameter int NUM_NOTES = 16,
    parameter int GAP_TICKS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         beat_tick,
    output logic [3:0]                   tone,
    output logic                         sound_en,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_NOTES)-1:0] note_idx
);
    localparam int            IW       = $clog2(NUM_NOTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NOTES - 1);
    localparam logic [3:0]    GAP_LOAD = 4'(GAP_TICKS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Entry layout {rest, dur[3:0], tone[3:0]}; dur==0 marks the end of the melody.
    function automatic logic [8:0] melody_rom(input logic [IW-1:0] addr);
        logic [31:0] a;
        a = 32'(addr);
        case (a)
            32'd0:   melody_rom = {1'b0, 4'd2, 4'd2};
            32'd1:   melody_rom = {1'b0, 4'd2, 4'd3};
            32'd2:   melody_rom = {1'b0, 4'd2, 4'd4};
            32'd3:   melody_rom = {1'b1, 4'd1, 4'd0};
            32'd4:   melody_rom = {1'b0, 4'd4, 4'd7};
            default: melody_rom = 9'd0;
        endcase
    endfunction

    logic [1:0]    state;
    logic [8:0]    cur_entry;
    logic [3:0]    dur_cnt;
    logic [3:0]    gap_cnt;
    logic          cur_rest;
    logic [3:0]    cur_dur;
    logic [3:0]    cur_tone;
    logic [IW-1:0] next_idx;
    logic          advance;
    logic          at_end;

    assign cur_rest = cur_entry[8];
    assign cur_dur  = cur_entry[7:4];
    assign cur_tone = cur_entry[3:0];
    assign next_idx = note_idx + IW'(1);
    assign busy     = (state != S_IDLE);

    // A note boundary: the last tick of a note with no gap following, or the last gap tick.
    always_comb begin
        advance = 1'b0;
        if (beat_tick) begin
            if (state == S_PLAY && dur_cnt == 4'd1 && (cur_rest || GAP_TICKS == 0)) begin
                advance = 1'b1;
            end
            if (state == S_GAP && gap_cnt == 4'd1) begin
                advance = 1'b1;
            end
        end
    end

    // Melody ends on an end marker, or when advancing past the final table entry.
    assign at_end = (state == S_LOAD && cur_dur == 4'd0) || (advance && note_idx == LAST_IDX);

    // Sequencer FSM; the table read is issued one cycle ahead of LOAD into cur_entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_entry <= 9'd0;
            dur_cnt   <= 4'd0;
            gap_cnt   <= 4'd0;
            tone      <= 4'd0;
            sound_en  <= 1'b0;
            done      <= 1'b0;
            note_idx  <= '0;
        end else if (stop) begin
            state    <= S_IDLE;
            sound_en <= 1'b0;
            done     <= 1'b0;
            note_idx <= '0;
        end else begin
            done <= 1'b0;
            if (at_end) begin
                sound_en <= 1'b0;
                note_idx <= '0;
`ifdef MELODY_LOOP_EN
                state     <= S_LOAD;
                cur_entry <= melody_rom('0);
`else
                state     <= S_IDLE;
                done      <= 1'b1;
`endif
            end else if (advance) begin
                state     <= S_LOAD;
                sound_en  <= 1'b0;
                note_idx  <= next_idx;
                cur_entry <= melody_rom(next_idx);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_LOAD;
                            note_idx  <= '0;
                            cur_entry <= melody_rom('0);
                        end
                    end
                    S_LOAD: begin
                        state    <= S_PLAY;
                        dur_cnt  <= cur_dur;
                        sound_en <= ~cur_rest;
                        if (!cur_rest) begin
                            tone <= cur_tone;
                        end
                    end
                    S_PLAY: begin
                        if (beat_tick) begin
                            dur_cnt <= dur_cnt - 4'd1;
                            if (dur_cnt == 4'd1) begin
                                state    <= S_GAP;
                                gap_cnt  <= GAP_LOAD;
                                sound_en <= 1'b0;
                            end
                        end
                    end
                    S_GAP: begin
                        if (beat_tick) begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
